// File: rtl/i2s_tx_param.sv
// Parametrised stereo I2S / left-justified DAC serializer with a one-frame
// holding buffer, mute, enable and underrun reporting.
module i2s_tx_param #(
  parameter int REF_CLK     = 18432000,
  parameter int SAMPLE_RATE = 48000,
  parameter int DATA_WIDTH  = 16,
  parameter int SLOT_WIDTH  = 16
) (
  input  logic                  CLK_18_4,
  input  logic                  RST_N,
  input  logic                  enable,
  input  logic                  mode,
  input  logic                  mute,
  input  logic [DATA_WIDTH-1:0] left_sample,
  input  logic [DATA_WIDTH-1:0] right_sample,
  input  logic                  sample_valid,
  output logic                  sample_ready,
  output logic                  frame_start,
  output logic                  underrun,
  output logic                  AUD_BCK,
  output logic                  AUD_LRCK,
  output logic                  AUD_DATA
);

  localparam int HALF       = REF_CLK / (SAMPLE_RATE * SLOT_WIDTH * 4);
  localparam int FRAME_BITS = 2 * SLOT_WIDTH;
  localparam int DIV_W      = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int CNT_W      = $clog2(FRAME_BITS);
  localparam int PAD_W      = SLOT_WIDTH - DATA_WIDTH;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(HALF - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_BITS - 1);
  localparam logic [CNT_W-1:0] SLOT_LEN = CNT_W'(SLOT_WIDTH);

  if (SLOT_WIDTH < DATA_WIDTH) begin : g_chk_slot
    $error("i2s_tx_param: SLOT_WIDTH must be >= DATA_WIDTH");
  end
  if ((HALF < 1) || ((REF_CLK % (SAMPLE_RATE * SLOT_WIDTH * 4)) != 0)) begin : g_chk_half
    $error("i2s_tx_param: REF_CLK / (SAMPLE_RATE*SLOT_WIDTH*4) must be an integer >= 1");
  end

  logic [DIV_W-1:0]      r_div;
  logic                  r_bck;
  logic [CNT_W-1:0]      r_bitcnt;
  logic                  r_lrck;
  logic [FRAME_BITS-1:0] r_shift;
  logic                  r_dly;
  logic                  r_data;
  logic                  r_mode;
  logic                  r_frame_start;
  logic                  r_underrun;
  logic                  r_full;
  logic                  r_ready;
  logic [DATA_WIDTH-1:0] r_buf_l;
  logic [DATA_WIDTH-1:0] r_buf_r;

  logic                  w_div_wrap;
  logic                  w_shift_evt;
  logic                  w_load;
  logic                  w_capture;
  logic                  w_mode_eff;
  logic [CNT_W-1:0]      w_bitcnt_next;
  logic [SLOT_WIDTH-1:0] w_left_slot;
  logic [SLOT_WIDTH-1:0] w_right_slot;
  logic [FRAME_BITS-1:0] w_new_frame;
  logic [FRAME_BITS-1:0] w_shift_next;

  assign w_div_wrap    = (r_div == DIV_LAST);
  assign w_shift_evt   = enable && w_div_wrap && r_bck;
  assign w_load        = w_shift_evt && (r_bitcnt == CNT_LAST);
  assign w_capture     = sample_valid && r_ready;
  assign w_bitcnt_next = (r_bitcnt == CNT_LAST) ? '0 : r_bitcnt + 1'b1;

  // Samples sit MSB-aligned in their slots with zero padding below.
  assign w_left_slot  = SLOT_WIDTH'(r_buf_l) << PAD_W;
  assign w_right_slot = SLOT_WIDTH'(r_buf_r) << PAD_W;
  assign w_new_frame  = (r_full && !mute) ? {w_left_slot, w_right_slot} : '0;
  assign w_shift_next = w_load ? w_new_frame : {r_shift[FRAME_BITS-2:0], 1'b0};
  assign w_mode_eff   = w_load ? mode : r_mode;

  // Serializer: divider, bit clock, frame position, shift register and pins.
  // In I2S mode the pin follows the delay flop, i.e. one BCK behind.
  always_ff @(posedge CLK_18_4 or negedge RST_N) begin
    if (!RST_N) begin
      r_div         <= '0;
      r_bck         <= 1'b0;
      r_bitcnt      <= CNT_LAST;
      r_lrck        <= 1'b0;
      r_shift       <= '0;
      r_dly         <= 1'b0;
      r_data        <= 1'b0;
      r_mode        <= 1'b0;
      r_frame_start <= 1'b0;
      r_underrun    <= 1'b0;
    end else if (!enable) begin
      r_div         <= '0;
      r_bck         <= 1'b0;
      r_bitcnt      <= CNT_LAST;
      r_lrck        <= 1'b0;
      r_shift       <= '0;
      r_dly         <= 1'b0;
      r_data        <= 1'b0;
      r_mode        <= 1'b0;
      r_frame_start <= 1'b0;
      r_underrun    <= 1'b0;
    end else begin
      r_frame_start <= w_load;
      r_underrun    <= w_load && !r_full;
      r_div         <= w_div_wrap ? '0 : r_div + 1'b1;
      if (w_div_wrap) begin
        r_bck <= ~r_bck;
      end
      if (w_shift_evt) begin
        r_bitcnt <= w_bitcnt_next;
        r_lrck   <= (w_bitcnt_next >= SLOT_LEN);
        r_shift  <= w_shift_next;
        r_dly    <= w_shift_next[FRAME_BITS-1];
        r_data   <= w_mode_eff ? r_dly : w_shift_next[FRAME_BITS-1];
        if (w_load) begin
          r_mode <= mode;
        end
      end
    end
  end

  // Holding buffer keeps running while the serializer is disabled.
  // Ready rises one clock after the emptying load and drops at capture.
  always_ff @(posedge CLK_18_4 or negedge RST_N) begin
    if (!RST_N) begin
      r_full  <= 1'b0;
      r_ready <= 1'b1;
      r_buf_l <= '0;
      r_buf_r <= '0;
    end else begin
      r_ready <= !r_full && !w_capture;
      if (w_capture) begin
        r_buf_l <= left_sample;
        r_buf_r <= right_sample;
        r_full  <= 1'b1;
      end else if (w_load && r_full) begin
        r_full <= 1'b0;
      end
    end
  end

  assign sample_ready = r_ready;
  assign frame_start  = r_frame_start;
  assign underrun     = r_underrun;
  assign AUD_BCK      = r_bck;
  assign AUD_LRCK     = r_lrck;
  assign AUD_DATA     = r_data;

endmodule

// File: tb/tb_i2s_tx_param.sv
// Directed bench for i2s_tx_param: a 16/16 left-justified instance and a
// 24/32 I2S instance, frames checked against a queue of expected words.
module tb_i2s_tx_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstN;

  logic        enA, modeA, muteA, validA;
  logic [15:0] leftA, rightA;
  logic        readyA, fsA, urA, bckA, lrckA, dataA;

  logic        enB, modeB, muteB, validB;
  logic [23:0] leftB, rightB;
  logic        readyB, fsB, urB, bckB, lrckB, dataB;

  logic [63:0] sbQ[$];
  int nTests = 0;
  int nFail  = 0;

  i2s_tx_param #(
    .REF_CLK(18432000), .SAMPLE_RATE(48000), .DATA_WIDTH(16), .SLOT_WIDTH(16)
  ) dutA (
    .CLK_18_4(clk), .RST_N(rstN), .enable(enA), .mode(modeA), .mute(muteA),
    .left_sample(leftA), .right_sample(rightA), .sample_valid(validA),
    .sample_ready(readyA), .frame_start(fsA), .underrun(urA),
    .AUD_BCK(bckA), .AUD_LRCK(lrckA), .AUD_DATA(dataA)
  );

  i2s_tx_param #(
    .REF_CLK(18432000), .SAMPLE_RATE(48000), .DATA_WIDTH(24), .SLOT_WIDTH(32)
  ) dutB (
    .CLK_18_4(clk), .RST_N(rstN), .enable(enB), .mode(modeB), .mute(muteB),
    .left_sample(leftB), .right_sample(rightB), .sample_valid(validB),
    .sample_ready(readyB), .frame_start(fsB), .underrun(urB),
    .AUD_BCK(bckB), .AUD_LRCK(lrckB), .AUD_DATA(dataB)
  );

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nTests++;
    assert (obs === exp) else begin
      nFail++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic reportTimeout(input string tag);
    nTests++;
    nFail++;
    $error("[TB] FAIL %s: observed timeout expected event", tag);
  endtask

  task automatic applyStimulus(input bit sel, input logic [31:0] l, input logic [31:0] r,
                               input string tag);
    int n;
    n = 0;
    while (!(sel ? readyB : readyA) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (!(sel ? readyB : readyA)) reportTimeout({tag, " ready wait"});
    if (sel) begin
      leftB = l[23:0]; rightB = r[23:0]; validB = 1'b1;
    end else begin
      leftA = l[15:0]; rightA = r[15:0]; validA = 1'b1;
    end
    @(negedge clk);
    validA = 1'b0;
    validB = 1'b0;
    checkOutput({tag, " ready fall"}, sel ? readyB : readyA, 0);
  endtask

  task automatic waitFrameStart(input bit sel, input string tag);
    int n;
    n = 0;
    while (!(sel ? fsB : fsA) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (!(sel ? fsB : fsA)) reportTimeout({tag, " frame_start"});
  endtask

  // Starts on the frame_start cycle; collects one frame on BCK rising edges
  // (I2S skips the first rise, which still carries the previous frame).
  task automatic captureBits(input bit sel, input bit i2s, input int act, input string tag,
                             output int frameLen);
    int nbits, skip, rises, cyc;
    logic [63:0] got, lrw, exp, expL;
    logic prevBck, b;
    nbits = sel ? 64 : 32;
    skip = i2s ? 1 : 0;
    rises = 0;
    cyc = 0;
    got = '0;
    lrw = '0;
    frameLen = 0;
    exp = (sbQ.size() > 0) ? sbQ.pop_front() : 64'hDEAD;
    prevBck = sel ? bckB : bckA;
    while (rises < nbits && cyc < 1000) begin
      @(negedge clk);
      cyc++;
      if ((sel ? fsB : fsA) && frameLen == 0) frameLen = cyc;
      b = sel ? bckB : bckA;
      if (b && !prevBck) begin
        if (skip > 0) skip--;
        else begin
          got = {got[62:0], sel ? dataB : dataA};
          lrw = {lrw[62:0], sel ? lrckB : lrckA};
          rises++;
          if (act == 1 && rises == 11) begin
            muteA = 1'b1;
            modeA = 1'b1;
          end
        end
      end
      prevBck = b;
    end
    if (rises < nbits) begin
      reportTimeout({tag, " bit capture"});
    end else begin
      expL = (64'd1 << (nbits / 2)) - 64'd1;
      if (i2s) expL = expL << 1;
      checkOutput({tag, " data"}, got, exp);
      checkOutput({tag, " lrck"}, lrw, expL);
    end
  endtask

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: observed no finish expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n, m, fl, fsSeen;
    rstN = 1'b0;
    enA = 1'b1; modeA = 1'b0; muteA = 1'b0; validA = 1'b0; leftA = '0; rightA = '0;
    enB = 1'b1; modeB = 1'b1; muteB = 1'b0; validB = 1'b0; leftB = '0; rightB = '0;
    repeat (3) @(negedge clk);

    checkOutput("reset bck", bckA, 0);
    checkOutput("reset lrck", lrckA, 0);
    checkOutput("reset data", dataA, 0);
    checkOutput("reset frame_start", fsA, 0);
    checkOutput("reset underrun", urA, 0);
    checkOutput("reset ready", readyA, 1);
    checkOutput("reset ready B", readyB, 1);

    // Defaults: timing of the first frames with no samples supplied.
    rstN = 1'b1;
    n = 0;
    while (!fsA && n < 100) begin @(negedge clk); n++; end
    checkOutput("first frame_start latency", n, 12);
    checkOutput("first frame underrun", urA, 1);
    n = 0;
    while (!bckA && n < 100) begin @(negedge clk); n++; end
    checkOutput("bck half period", n, 6);
    while (!lrckA && n < 500) begin @(negedge clk); n++; end
    checkOutput("lrck rise after load", n, 192);
    m = 0;
    while (!fsA && m < 500) begin @(negedge clk); m++; end
    checkOutput("lrck high time", m, 192);
    checkOutput("second frame underrun", urA, 1);

    // Left-justified frame.
    applyStimulus(0, 32'hA5C3, 32'h0F0F, "lj");
    sbQ.push_back(64'h0000_0000_A5C3_0F0F);
    waitFrameStart(0, "lj");
    checkOutput("lj no underrun", urA, 0);
    checkOutput("lj ready at load", readyA, 0);
    @(negedge clk);
    checkOutput("lj ready after load", readyA, 1);
    captureBits(0, 0, 0, "lj frame", fl);

    // I2S frame on the 24/32 instance.
    applyStimulus(1, 32'h80_0001, 32'h7F_FFFE, "i2s");
    sbQ.push_back(64'h8000_0100_7FFF_FE00);
    waitFrameStart(1, "i2s");
    checkOutput("i2s no underrun", urB, 0);
    captureBits(1, 1, 0, "i2s frame", fl);
    checkOutput("i2s frame length", fl, 384);

    // Sample offered exactly on the load cycle with the buffer empty.
    waitFrameStart(0, "collision");
    repeat (383) @(negedge clk);
    leftA = 16'h1234; rightA = 16'hFEDC; validA = 1'b1;
    @(negedge clk);
    validA = 1'b0;
    checkOutput("collision frame_start", fsA, 1);
    checkOutput("collision underrun", urA, 1);
    checkOutput("collision captured", readyA, 0);
    sbQ.push_back(64'h0);
    sbQ.push_back(64'h0000_0000_1234_FEDC);
    captureBits(0, 0, 0, "collision zero frame", fl);
    waitFrameStart(0, "collision next");
    checkOutput("collision no second underrun", urA, 0);
    captureBits(0, 0, 0, "collision pair frame", fl);

    // Mute and mode raised mid-frame take effect at the next load only.
    applyStimulus(0, 32'h5A5A, 32'h3C3C, "mute pre");
    sbQ.push_back(64'h0000_0000_5A5A_3C3C);
    sbQ.push_back(64'h0);
    waitFrameStart(0, "mute pre");
    @(negedge clk);
    applyStimulus(0, 32'h7777, 32'h1111, "mute next");
    captureBits(0, 0, 1, "pre-mute frame", fl);
    waitFrameStart(0, "mute");
    checkOutput("mute frame no underrun", urA, 0);
    checkOutput("mute ready at load", readyA, 0);
    @(negedge clk);
    checkOutput("mute consumes buffer", readyA, 1);
    captureBits(0, 1, 0, "muted i2s frame", fl);
    muteA = 1'b0;
    modeA = 1'b0;

    // Enable dropped mid-frame with a pair waiting in the buffer.
    waitFrameStart(0, "enable");
    applyStimulus(0, 32'hC001, 32'h0DD5, "enable");
    sbQ.push_back(64'h0000_0000_C001_0DD5);
    repeat (239) @(negedge clk);
    checkOutput("lrck before disable", lrckA, 1);
    enA = 1'b0;
    @(negedge clk);
    checkOutput("disable bck", bckA, 0);
    checkOutput("disable lrck", lrckA, 0);
    checkOutput("disable data", dataA, 0);
    fsSeen = 0;
    repeat (50) begin
      @(negedge clk);
      if (fsA || urA) fsSeen++;
    end
    checkOutput("disable no pulses", fsSeen, 0);
    checkOutput("disable buffer retained", readyA, 0);
    enA = 1'b1;
    n = 0;
    while (!fsA && n < 100) begin @(negedge clk); n++; end
    checkOutput("re-enable load latency", n, 12);
    checkOutput("re-enable no underrun", urA, 0);
    captureBits(0, 0, 0, "re-enable frame", fl);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
